// File: rtl/counter_arbiter_if.sv
// Bundle between the burst requesters, the 4-bit mode counter and counter_arbiter.
// The arbiter connects through the slave modport. The environment (requesters plus counter)
// connects through the master modport.
interface counter_arbiter_if #(
  parameter int unsigned LEN_W = 4,
  parameter int unsigned RCO_W = 4
) ();

  // Requester 0 command
  logic             req0;
  logic [1:0]       mode0;
  logic [3:0]       d0;
  logic [LEN_W-1:0] len0;

  // Requester 1 command
  logic             req1;
  logic [1:0]       mode1;
  logic [3:0]       d1;
  logic [LEN_W-1:0] len1;

  // Grant / completion status
  logic             gnt0;
  logic             gnt1;
  logic             done0;
  logic             done1;
  logic             aborted;
  logic [RCO_W-1:0] rco_cnt;
  logic             busy;

  // Shared counter controls and observed counter signals
  logic             enable_;
  logic [1:0]       mode_;
  logic [3:0]       D_;
  logic             rco_;
  logic             load_;

  modport master (
    output req0, mode0, d0, len0,
    output req1, mode1, d1, len1,
    output rco_, load_,
    input  gnt0, gnt1, done0, done1, aborted, rco_cnt, busy,
    input  enable_, mode_, D_
  );

  modport slave (
    input  req0, mode0, d0, len0,
    input  req1, mode1, d1, len1,
    input  rco_, load_,
    output gnt0, gnt1, done0, done1, aborted, rco_cnt, busy,
    output enable_, mode_, D_
  );

endinterface

// File: rtl/counter_arbiter.sv
// Two-requester burst arbiter for the shared 4-bit mode counter.
// A winning requester's mode, load value and length are latched in IDLE. The counter is then
// set up for one cycle and enabled for the burst length. Completion is reported with a done
// pulse, and an aborted flag if the requester dropped req mid-burst.
// Optional build macro COUNTER_ARB_FIXED_PRIO_EN: requester 0 always wins contention.
// When it is undefined (the default), contention is resolved round-robin.
module counter_arbiter #(
  parameter int unsigned LEN_W = 4,
  parameter int unsigned RCO_W = 4
) (
  input logic              clk,
  input logic              reset,
  counter_arbiter_if.slave bus
);

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] SETUP = 2'd1;
  localparam logic [1:0] RUN   = 2'd2;
  localparam logic [1:0] DONE  = 2'd3;

  localparam logic [LEN_W-1:0] LEN_ONE = LEN_W'(1);
  localparam logic [RCO_W-1:0] RCO_ONE = RCO_W'(1);
  localparam logic [RCO_W-1:0] RCO_MAX = {RCO_W{1'b1}};

  logic [1:0]       state_q, state_d;
  logic             sel_q, sel_d;                  // requester owning the current burst
  logic             last_served_q, last_served_d;
  logic [1:0]       mode_q, mode_d;                // drives mode_ directly
  logic [3:0]       data_q, data_d;                // drives D_ directly
  logic [LEN_W-1:0] remaining_q, remaining_d;
  logic [RCO_W-1:0] rco_cnt_q, rco_cnt_d;
  logic             aborted_q, aborted_d;

  logic             pick_valid;
  logic             pick;
  logic [1:0]       pick_mode;
  logic [3:0]       pick_data;
  logic [LEN_W-1:0] pick_len_raw;
  logic [LEN_W-1:0] pick_len;
  logic             granted_req;
  logic             owns_counter;

  // load_ is observed by the environment only; the FSM never needs it.
  logic unused_sig;
  assign unused_sig = ^{bus.load_, last_served_q};

  // Choose which requester wins the next contest in IDLE.
  always_comb begin
    pick_valid = bus.req0 | bus.req1;
    pick       = 1'b0;
    if (bus.req0 && bus.req1) begin
`ifdef COUNTER_ARB_FIXED_PRIO_EN
      pick = 1'b0;
`else
      pick = ~last_served_q;
`endif
    end else if (bus.req1) begin
      pick = 1'b1;
    end
  end

  // Mux the winning requester's command; a zero length runs as a single cycle.
  always_comb begin
    pick_mode    = pick ? bus.mode1 : bus.mode0;
    pick_data    = pick ? bus.d1    : bus.d0;
    pick_len_raw = pick ? bus.len1  : bus.len0;
    pick_len     = (pick_len_raw == '0) ? LEN_ONE : pick_len_raw;
  end

  // Next-state logic for the burst FSM and its datapath.
  always_comb begin
    state_d       = state_q;
    sel_d         = sel_q;
    last_served_d = last_served_q;
    mode_d        = mode_q;
    data_d        = data_q;
    remaining_d   = remaining_q;
    rco_cnt_d     = rco_cnt_q;
    aborted_d     = aborted_q;
    granted_req   = sel_q ? bus.req1 : bus.req0;

    unique case (state_q)
      IDLE: begin
        if (pick_valid) begin
          // The command is captured here. Later changes on the request inputs are ignored.
          sel_d       = pick;
          mode_d      = pick_mode;
          data_d      = pick_data;
          remaining_d = pick_len;
          rco_cnt_d   = '0;
          aborted_d   = 1'b0;
          state_d     = SETUP;
        end
      end
      SETUP: begin
        state_d = RUN;
      end
      RUN: begin
        remaining_d = remaining_q - LEN_ONE;
        if (bus.rco_ && (rco_cnt_q != RCO_MAX)) begin
          rco_cnt_d = rco_cnt_q + RCO_ONE;
        end
        // A dropped request ends the burst early even on its final cycle.
        if (!granted_req) begin
          aborted_d = 1'b1;
          state_d   = DONE;
        end else if (remaining_q == LEN_ONE) begin
          state_d = DONE;
        end
      end
      DONE: begin
        last_served_d = sel_q;
        state_d       = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State and datapath registers; reset drops any burst in flight without a done pulse.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q       <= IDLE;
      sel_q         <= 1'b0;
      last_served_q <= 1'b1;
      mode_q        <= 2'b00;
      data_q        <= 4'h0;
      remaining_q   <= '0;
      rco_cnt_q     <= '0;
      aborted_q     <= 1'b0;
    end else begin
      state_q       <= state_d;
      sel_q         <= sel_d;
      last_served_q <= last_served_d;
      mode_q        <= mode_d;
      data_q        <= data_d;
      remaining_q   <= remaining_d;
      rco_cnt_q     <= rco_cnt_d;
      aborted_q     <= aborted_d;
    end
  end

  // Outputs are decoded from registered state only, so there is no input-to-output path.
  assign owns_counter = (state_q == SETUP) || (state_q == RUN);
  assign bus.gnt0     = owns_counter & ~sel_q;
  assign bus.gnt1     = owns_counter &  sel_q;
  assign bus.done0    = (state_q == DONE) & ~sel_q;
  assign bus.done1    = (state_q == DONE) &  sel_q;
  assign bus.aborted  = (state_q == DONE) & aborted_q;
  assign bus.rco_cnt  = rco_cnt_q;
  assign bus.busy     = (state_q != IDLE);
  assign bus.enable_  = (state_q == RUN);
  assign bus.mode_    = mode_q;
  assign bus.D_       = data_q;

  // Grants never overlap and only one requester completes per cycle.
  a_gnt_excl: assert property (@(posedge clk) disable iff (reset) !(bus.gnt0 && bus.gnt1));
  a_done_excl: assert property (@(posedge clk) disable iff (reset) !(bus.done0 && bus.done1));
  // The counter is only enabled while someone holds a grant.
  a_en_gnt: assert property (@(posedge clk) disable iff (reset)
                             bus.enable_ |-> (bus.gnt0 || bus.gnt1));

endmodule

// File: tb/tb_counter_arbiter.sv
// Directed bench for counter_arbiter: a per-cycle vector table for single, zero-length and
// load-mode bursts, plus hand-written abort, contention and mid-burst reset sequences.
module tb_counter_arbiter;

  localparam int unsigned LEN_W = 4;
  localparam int unsigned RCO_W = 4;

  logic clk;
  logic reset;
  int   n_checks;
  int   n_fail;

  counter_arbiter_if #(.LEN_W(LEN_W), .RCO_W(RCO_W)) bus ();

  counter_arbiter #(.LEN_W(LEN_W), .RCO_W(RCO_W)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Small counter model: 00 up, 01 down, 11 load D_, otherwise hold.
  logic [3:0] cnt;
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt <= 4'h0;
    end else if (bus.enable_) begin
      case (bus.mode_)
        2'b00:   cnt <= cnt + 4'h1;
        2'b01:   cnt <= cnt - 4'h1;
        2'b11:   cnt <= bus.D_;
        default: cnt <= cnt;
      endcase
    end
  end
  assign bus.load_ = bus.enable_ && (bus.mode_ == 2'b11);

  typedef struct packed {
    logic       req0;
    logic [1:0] mode0;
    logic [3:0] d0;
    logic [3:0] len0;
    logic       req1;
    logic [1:0] mode1;
    logic [3:0] d1;
    logic [3:0] len1;
    logic       rco;
    logic [6:0] flags;   // {gnt0, gnt1, enable_, done0, done1, aborted, busy}
    logic [1:0] mode;
    logic [3:0] data;
    logic [3:0] rcnt;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mk(input logic r0, input logic [1:0] m0, input logic [3:0] d0,
                              input logic [3:0] l0, input logic r1, input logic [1:0] m1,
                              input logic [3:0] d1, input logic [3:0] l1, input logic rco,
                              input logic [6:0] flags, input logic [1:0] mode,
                              input logic [3:0] data, input logic [3:0] rcnt);
    vec_t v;
    v.req0 = r0;  v.mode0 = m0; v.d0 = d0; v.len0 = l0;
    v.req1 = r1;  v.mode1 = m1; v.d1 = d1; v.len1 = l1;
    v.rco = rco;  v.flags = flags; v.mode = mode; v.data = data; v.rcnt = rcnt;
    return v;
  endfunction

  function automatic logic [16:0] outs();
    return {bus.gnt0, bus.gnt1, bus.enable_, bus.done0, bus.done1, bus.aborted, bus.busy,
            bus.mode_, bus.D_, bus.rco_cnt};
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic apply(input vec_t v);
    bus.req0 = v.req0; bus.mode0 = v.mode0; bus.d0 = v.d0; bus.len0 = v.len0;
    bus.req1 = v.req1; bus.mode1 = v.mode1; bus.d1 = v.d1; bus.len1 = v.len1;
    bus.rco_ = v.rco;
  endtask

  initial begin
    int   en_cycles;
    int   cyc;
    int   n_gnt;
    int   gnt_id[8];
    int   gnt_cyc[8];
    logic prev_g0, prev_g1;

    n_checks = 0;
    n_fail   = 0;
    reset    = 1'b1;
    bus.req0 = 1'b0; bus.mode0 = 2'b00; bus.d0 = 4'h0; bus.len0 = 4'h0;
    bus.req1 = 1'b0; bus.mode1 = 2'b00; bus.d1 = 4'h0; bus.len1 = 4'h0;
    bus.rco_ = 1'b0;

    // Single burst, len 5, with rco_ pulses in SETUP and DONE that must not count
    vecs.push_back(mk(1, 2'b00, 4'h0, 4'd5, 0, 2'b00, 4'h0, 4'd0, 0, 7'b1000001, 2'b00, 4'h0, 4'd0));
    vecs.push_back(mk(1, 2'b00, 4'h0, 4'd5, 0, 2'b00, 4'h0, 4'd0, 1, 7'b1010001, 2'b00, 4'h0, 4'd0));
    vecs.push_back(mk(1, 2'b00, 4'h0, 4'd5, 0, 2'b00, 4'h0, 4'd0, 1, 7'b1010001, 2'b00, 4'h0, 4'd1));
    vecs.push_back(mk(1, 2'b00, 4'h0, 4'd5, 0, 2'b00, 4'h0, 4'd0, 0, 7'b1010001, 2'b00, 4'h0, 4'd1));
    vecs.push_back(mk(1, 2'b00, 4'h0, 4'd5, 0, 2'b00, 4'h0, 4'd0, 1, 7'b1010001, 2'b00, 4'h0, 4'd2));
    vecs.push_back(mk(1, 2'b00, 4'h0, 4'd5, 0, 2'b00, 4'h0, 4'd0, 0, 7'b1010001, 2'b00, 4'h0, 4'd2));
    vecs.push_back(mk(1, 2'b00, 4'h0, 4'd5, 0, 2'b00, 4'h0, 4'd0, 1, 7'b0001001, 2'b00, 4'h0, 4'd3));
    vecs.push_back(mk(0, 2'b00, 4'h0, 4'd5, 0, 2'b00, 4'h0, 4'd0, 1, 7'b0000000, 2'b00, 4'h0, 4'd3));
    vecs.push_back(mk(0, 2'b00, 4'h0, 4'd5, 0, 2'b00, 4'h0, 4'd0, 1, 7'b0000000, 2'b00, 4'h0, 4'd3));
    // Zero-length burst on requester 1; command changes after latching are ignored
    vecs.push_back(mk(0, 2'b00, 4'h0, 4'd0, 1, 2'b01, 4'h5, 4'd0, 0, 7'b0100001, 2'b01, 4'h5, 4'd0));
    vecs.push_back(mk(0, 2'b00, 4'h0, 4'd0, 1, 2'b00, 4'hF, 4'd0, 1, 7'b0110001, 2'b01, 4'h5, 4'd0));
    vecs.push_back(mk(0, 2'b00, 4'h0, 4'd0, 1, 2'b00, 4'hF, 4'd0, 1, 7'b0000101, 2'b01, 4'h5, 4'd1));
    vecs.push_back(mk(0, 2'b00, 4'h0, 4'd0, 0, 2'b00, 4'hF, 4'd0, 0, 7'b0000000, 2'b01, 4'h5, 4'd1));
    // Load mode, len 1
    vecs.push_back(mk(1, 2'b11, 4'hA, 4'd1, 0, 2'b00, 4'h0, 4'd0, 0, 7'b1000001, 2'b11, 4'hA, 4'd0));
    vecs.push_back(mk(1, 2'b11, 4'h3, 4'd1, 0, 2'b00, 4'h0, 4'd0, 0, 7'b1010001, 2'b11, 4'hA, 4'd0));
    vecs.push_back(mk(1, 2'b11, 4'h3, 4'd1, 0, 2'b00, 4'h0, 4'd0, 0, 7'b0001001, 2'b11, 4'hA, 4'd0));
    vecs.push_back(mk(0, 2'b11, 4'h3, 4'd1, 0, 2'b00, 4'h0, 4'd0, 0, 7'b0000000, 2'b11, 4'hA, 4'd0));

    // Reset state
    repeat (2) tick();
    check("reset_outputs", 32'(outs()), 32'h0);
    reset = 1'b0;

    for (int i = 0; i < vecs.size(); i++) begin
      apply(vecs[i]);
      tick();
      check($sformatf("vec%0d", i), 32'(outs()),
            32'({vecs[i].flags, vecs[i].mode, vecs[i].data, vecs[i].rcnt}));
    end
    check("load_counter_value", 32'(cnt), 32'hA);

    // Abort: req0 dropped during the 3rd RUN cycle of an 8-cycle burst
    bus.req0 = 1'b1; bus.mode0 = 2'b00; bus.d0 = 4'h0; bus.len0 = 4'd8; bus.rco_ = 1'b0;
    en_cycles = 0;
    tick();
    check("abort_setup_gnt0", 32'(bus.gnt0), 32'h1);
    for (int i = 0; i < 3; i++) begin
      tick();
      if (bus.enable_) en_cycles++;
    end
    bus.req0 = 1'b0;
    tick();
    if (bus.enable_) en_cycles++;
    check("abort_enable_cycles", 32'(en_cycles), 32'd3);
    check("abort_done", 32'({bus.done0, bus.aborted, bus.enable_, bus.gnt0}), 32'b1100);
    tick();
    check("abort_idle", 32'({bus.busy, bus.done0, bus.aborted}), 32'b000);

    // Contention: both held high, len 3 each
    bus.req0 = 1'b1; bus.len0 = 4'd3;
    bus.req1 = 1'b1; bus.len1 = 4'd3; bus.mode1 = 2'b00; bus.d1 = 4'h0;
    n_gnt = 0; prev_g0 = 1'b0; prev_g1 = 1'b0;
    for (cyc = 1; cyc <= 24; cyc++) begin
      tick();
      check("gnt_overlap", 32'(bus.gnt0 && bus.gnt1), 32'h0);
      if (n_gnt < 8 && ((bus.gnt0 && !prev_g0) || (bus.gnt1 && !prev_g1))) begin
        gnt_id[n_gnt]  = bus.gnt1 ? 1 : 0;
        gnt_cyc[n_gnt] = cyc;
        n_gnt++;
      end
      prev_g0 = bus.gnt0;
      prev_g1 = bus.gnt1;
    end
    bus.req0 = 1'b0;
    bus.req1 = 1'b0;
    check("contention_grant_count", 32'(n_gnt), 32'd4);
    for (int i = 0; i < 4 && i < n_gnt; i++) begin
`ifdef COUNTER_ARB_FIXED_PRIO_EN
      check($sformatf("contention_id%0d", i), 32'(gnt_id[i]), 32'd0);
`else
      // Requester 0 was served last, so requester 1 wins the first contest.
      check($sformatf("contention_id%0d", i), 32'(gnt_id[i]), 32'((i + 1) % 2));
`endif
      check($sformatf("contention_cycle%0d", i), 32'(gnt_cyc[i]), 32'(1 + 6 * i));
    end
    tick();
    check("contention_idle", 32'(bus.busy), 32'h0);

    // Reset in the middle of RUN
    bus.req0 = 1'b1; bus.mode0 = 2'b10; bus.d0 = 4'h7; bus.len0 = 4'd8;
    tick();
    tick();
    check("pre_reset_run", 32'({bus.enable_, bus.mode_, bus.D_}), 32'({1'b1, 2'b10, 4'h7}));
    #3;
    reset = 1'b1;
    #1;
    check("midreset_outputs", 32'(outs()), 32'h0);
    tick();
    check("midreset_no_done", 32'({bus.done0, bus.done1, bus.busy}), 32'h0);
    reset = 1'b0;
    bus.req0 = 1'b1; bus.len0 = 4'd2;
    bus.req1 = 1'b1; bus.len1 = 4'd2;
    tick();
    check("post_reset_first_gnt", 32'({bus.gnt0, bus.gnt1}), 32'b10);
    bus.req0 = 1'b0;
    bus.req1 = 1'b0;
    repeat (4) tick();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/counter_arbiter.md
Name: counter_arbiter

Overview:
- Shares the single 4-bit mode counter (ports enable_, mode_, D_, rco_, load_) between two requesters.
- Each requester asks for a burst: a mode, a load value and a length in cycles.
- The arbiter grants the requesters round-robin, drives the counter controls for the burst, counts rco_ pulses seen during the burst, and signals completion.
- It sits between the requester logic and the counter, in place of the bench driver.

Parameters:
- LEN_W, 4, width of the burst length inputs.
- RCO_W, 4, width of the rco_ event counter (rco_cnt).

Ports:
- clk  in  1  system clock; all state changes on the rising edge.
- reset  in  1  asynchronous, active-high reset.
- req0  in  1  requester 0 burst request; held high until done0 or abort.
- mode0  in  2  requester 0 counter mode.
- d0  in  4  requester 0 load value.
- len0  in  LEN_W  requester 0 burst length; 0 is treated as 1.
- req1, mode1, d1, len1  in  1/2/4/LEN_W  the same set for requester 1.
- gnt0  out  1  requester 0 owns the counter.
- gnt1  out  1  requester 1 owns the counter.
- done0  out  1  one-cycle pulse: requester 0 burst finished.
- done1  out  1  one-cycle pulse: requester 1 burst finished.
- aborted  out  1  qualifies the done pulse: 1 means the burst was cut short because req dropped.
- rco_cnt  out  RCO_W  rco_ pulses seen in the last burst; valid while done is high and held afterwards.
- busy  out  1  FSM is not in IDLE.
- enable_  out  1  counter enable.
- mode_  out  2  counter mode.
- D_  out  4  counter load data.
- rco_  in  1  counter ripple carry.
- load_  in  1  counter load indication (monitored only, not used by the FSM).

Behaviour:
Reset (asynchronous, immediate, also in the middle of a burst):
- State goes to IDLE.
- All outputs go to 0, including mode_, D_ and rco_cnt.
- last_served = 1, so requester 0 wins the first contest.
- Any burst in progress is dropped, with no done pulse.

States:
- IDLE
  - Outputs: enable_=0; mode_ and D_ hold their last values.
  - Request selection:
    - No request: stay in IDLE.
    - One request: select that requester.
    - Both requests: select the requester that is not last_served.
  - The selected requester's mode, d and len are latched. len==0 is latched as 1.
  - Next state SETUP.
- SETUP (exactly 1 cycle)
  - gnt of the selected requester = 1.
  - mode_ and D_ are driven from the latched command; enable_=0.
  - rco_cnt is cleared; remaining = latched len.
  - Next state RUN.
- RUN
  - gnt held; enable_=1; mode_ and D_ are stable from the latched command.
  - Each cycle: remaining decrements.
  - Each cycle with rco_=1: rco_cnt increments, saturating at 2^RCO_W-1.
  - When remaining==1 at a clock edge, next state is DONE.
  - If the granted req is low at a clock edge, next state is DONE with aborted=1.
- DONE (1 cycle)
  - enable_=0; gnt=0.
  - done of the served requester = 1; aborted is driven.
  - last_served = served requester.
  - Next state IDLE.

Latency and throughput:
- req high at edge t (in IDLE): gnt high after t+1, enable_ high after t+2.
- A burst of length L gives exactly L cycles with enable_=1.
- The done pulse comes after edge t+2+L.
- Back-to-back bursts: IDLE takes 1 cycle between DONE and the next SETUP, so the minimum period is L+3 cycles.

Boundary and hazard rules:
- gnt0 and gnt1 are never high in the same cycle.
- Changes on mode0/mode1/d0/d1/len0/len1 after latching are ignored.
- The request of the non-selected requester is ignored until the FSM returns to IDLE.
- rco_ is sampled only in RUN; an rco_ high during SETUP, DONE or IDLE is not counted.
- mode_ is passed through unchanged; the counter owns the meaning of each mode (2'b11 = load D_).

Optional Feature:
- Macro: COUNTER_ARB_FIXED_PRIO_EN.
- Defined: requester 0 always wins when both requests are high; last_served is not used.
- Undefined (default): round-robin as described above.

Test Plan:
- Single burst: req0=1, mode0=2'b00, d0=4'h0, len0=5, req1=0 -> gnt0 rises 1 cycle after req0; enable_=1 for exactly 5 cycles; done0 pulses once with aborted=0; rco_cnt equals the number of rco_ pulses in the window.
- Contention and fairness: req0 and req1 held high continuously, len=3 each -> grants alternate 0,1,0,1 with a period of 6 cycles; gnt0 and gnt1 never overlap. With COUNTER_ARB_FIXED_PRIO_EN defined, every grant goes to 0.
- Zero length: len1=0, req1=1 -> exactly 1 cycle with enable_=1, then done1.
- Abort: req0 dropped on the 3rd RUN cycle of an 8-cycle burst -> enable_ falls after 3 cycles; done0=1 with aborted=1 in the same cycle; returns to IDLE.
- Load mode: mode0=2'b11, d0=4'hA, len0=1 -> mode_=2'b11 and D_=4'hA from SETUP onward; the counter output reads 4'hA after RUN; rco_cnt=0.
- Reset mid-burst: reset asserted in RUN between clock edges -> all outputs 0 immediately with no done pulse; after release, req0 and req1 both high -> requester 0 is granted first.
